// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: data width, canonical NOP, fetch FSM states
// and the payload stored in the prefetch queue.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode instruction handshake; the fetch unit is the master.
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (output instr_valid, output instr, output instr_pc, input instr_ready);
  modport slave  (input instr_valid, input instr, input instr_pc, output instr_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; flush takes priority over push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited word requests to imem, in-order prefetch
// queue toward decode, redirect flush with discard of in-flight responses.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [XLEN-1:0]     imem_rsp_data,
  instr_fetch_unit_if.master  dec_if,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                halt
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_t    state_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   q_count;
  logic            q_empty, q_full, q_push, q_pop;
  fetch_entry_t    q_wdata, q_rdata;

  logic [XLEN-1:0] tag_pc;
  logic [CW-1:0]   tag_count;
  logic            tag_empty, tag_full;

  logic [SW-1:0]   credit_used;
  logic            req_fire;
  logic            rsp_drop;

  // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
  assign credit_used    = SW'(q_count) + SW'(outstanding_q);
  assign imem_req_valid = (state_q == RUN) && (credit_used < SW'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (discard_q != '0);
  assign q_push   = imem_rsp_valid && !rsp_drop;
  assign q_pop    = !q_empty && dec_if.instr_ready;
  assign q_wdata  = '{word: imem_rsp_data, pc: tag_pc};

  assign dec_if.instr_valid = !q_empty;
  assign dec_if.instr       = q_rdata.word;
  assign dec_if.instr_pc    = q_rdata.pc;

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d     = discard_q - CW'(rsp_drop);
    fetch_pc_d    = fetch_pc_q;
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    // Everything still in flight after this edge belongs to the old stream.
    if (redirect) begin
      discard_d  = outstanding_d;
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      case (state_q)
        BOOT:    state_q <= RUN;
        RUN:     if (halt)  state_q <= HALT;
        HALT:    if (!halt) state_q <= RUN;
        default: state_q <= BOOT;
      endcase
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_prefetch_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  // Tags are never flushed: stale tags drain alongside their responses.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .wdata (fetch_pc_q),
    .rdata (tag_pc),
    .empty (tag_empty),
    .full  (tag_full),
    .count (tag_count)
  );

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_q <= CW'(DEPTH));
  a_discard_bound: assert property (@(posedge clk) disable iff (!rst_n)
    discard_q <= outstanding_q);
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0) && !tag_empty);
  a_tag_tracks: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == outstanding_q);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !tag_full);
  a_q_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    q_push |-> (!q_full || q_pop || redirect));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: imem responder with variable latency,
// and a stream scoreboard expecting consecutive PCs from the last redirect/reset.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        redirect, halt;
  logic [31:0] redirect_pc;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_if         (bus),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  int checks = 0;
  int failures = 0;
  int n_consumed = 0;
  int n_accept = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int rdy_pct = 100;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] mexp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Instruction memory: in-order responses, latency drawn per request.
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mexp           = RESET_PC;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        mexp = RESET_PC;
      end else begin
        if (imem_rsp_valid && pend.size() > 0) pend.delete(0);
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_addr, mexp);
          pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
          n_accept++;
          chk("credit_bound", 32'(pend.size() <= DEPTH), 32'd1);
          mexp = mexp + 32'd4;
        end
        if (redirect) mexp = {redirect_pc[31:2], 2'b00};
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [31:0] sb_q[$];
    logic [31:0] sb_next, e, prev_pc, prev_word;
    logic        prev_hold, prev_halt;
    sb_next   = RESET_PC;
    prev_hold = 1'b0;
    prev_halt = 1'b0;
    prev_pc   = 32'h0;
    prev_word = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, 32'd0);
        sb_q.delete();
        sb_next   = RESET_PC;
        prev_hold = 1'b0;
        prev_halt = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", 32'(bus.instr_valid), 32'd1);
          chk("hold_pc", bus.instr_pc, prev_pc);
          chk("hold_word", bus.instr, prev_word);
        end
        if (prev_halt && halt) chk("halt_no_req", 32'(imem_req_valid), 32'd0);
        if (redirect) begin
          sb_q.delete();
          sb_next = {redirect_pc[31:2], 2'b00};
        end else if (bus.instr_valid && bus.instr_ready) begin
          while (sb_q.size() < 4) begin
            sb_q.push_back(sb_next);
            sb_next = sb_next + 32'd4;
          end
          e = sb_q.pop_front();
          chk("instr_pc", bus.instr_pc, e);
          chk("instr_word", bus.instr, mem_word(e));
          n_consumed++;
        end
        prev_hold = bus.instr_valid && !bus.instr_ready && !redirect;
        prev_pc   = bus.instr_pc;
        prev_word = bus.instr;
        prev_halt = halt;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called at posedge+2; asserts reset mid-cycle, releases, checks boot timing.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("async_instr", bus.instr, 32'd0);
    chk("async_instr_pc", bus.instr_pc, 32'd0);
    tick(2);
    #1;
    rst_n = 1'b1;
    #1;
    chk("boot_no_req", 32'(imem_req_valid), 32'd0);
    tick(1);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_addr, RESET_PC);
  endtask

  task automatic wait_pend(input int n, input string name);
    for (int i = 0; i < 60 && pend.size() != n; i++) tick(1);
    chk(name, 32'(pend.size() == n), 32'd1);
  endtask

  initial begin
    int a0, c0;
    rst_n           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'h0;
    halt            = 1'b0;
    bus.instr_ready = 1'b1;
    tick(3);

    // Streaming with single-cycle memory: one instruction per cycle.
    do_reset();
    tick(12);
    c0 = n_consumed;
    tick(10);
    chk("steady_rate", 32'(n_consumed - c0), 32'd10);

    // Decoder stalled: credit stops requests at DEPTH.
    bus.instr_ready = 1'b0;
    do_reset();
    a0 = n_accept;
    tick(14);
    chk("stall_req_count", 32'(n_accept - a0), 32'd4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_pc", bus.instr_pc, RESET_PC);
    bus.instr_ready = 1'b1;
    c0 = n_consumed;
    tick(10);
    chk("stall_drain", 32'(n_consumed - c0 >= 4), 32'd1);

    // Redirect with two requests in flight at 3-cycle latency.
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_pend(2, "t3_two_inflight");
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick(1);
    redirect = 1'b0;
    chk("t3_new_addr", imem_addr, 32'h0000_0100);
    c0 = n_consumed;
    tick(20);
    chk("t3_progress", 32'(n_consumed > c0), 32'd1);

    // Redirect coinciding with acceptance and response.
    lat_min = 1; lat_max = 1;
    tick(10);
    for (int i = 0; i < 60 && !(imem_rsp_valid && imem_req_valid && imem_req_ready); i++) tick(1);
    chk("t4_collision", 32'(imem_rsp_valid && imem_req_valid && imem_req_ready), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    tick(1);
    redirect = 1'b0;
    tick(10);

    // Unaligned redirect target and address wrap.
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick(1);
    redirect = 1'b0;
    chk("align_addr", imem_addr, 32'h0000_0200);
    tick(10);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pre_valid", 32'(imem_req_valid && imem_req_ready), 32'd1);
    tick(1);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    tick(10);

    // Halt with two in flight: they still arrive and are delivered.
    lat_min = 3; lat_max = 3;
    do_reset();
    a0 = n_accept;
    c0 = n_consumed;
    wait_pend(2, "t6_two_inflight");
    halt = 1'b1;
    tick(1);
    tick(1);
    chk("halt_no_new_req_a", 32'(imem_req_valid), 32'd0);
    begin
      int a1;
      a1 = n_accept;
      tick(10);
      chk("halt_accept_frozen", 32'(n_accept - a1), 32'd0);
    end
    chk("halt_drained", 32'(pend.size()), 32'd0);
    chk("halt_all_delivered", 32'(n_consumed - c0), 32'(n_accept - a0));
    halt = 1'b0;
    tick(6);
    do_reset();
    tick(5);

    // Randomized traffic.
    lat_min = 1; lat_max = 4; rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      bus.instr_ready = (int'($urandom_range(0, 99)) < 75);
      if (redirect) redirect = 1'b0;
      else if (int'($urandom_range(0, 99)) < 3) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
      end
      if (int'($urandom_range(0, 99)) < 3) halt = !halt;
      tick(1);
    end
    redirect = 1'b0; halt = 1'b0; bus.instr_ready = 1'b1; rdy_pct = 100;
    tick(20);
    c0 = n_consumed;
    tick(20);
    chk("final_progress", 32'(n_consumed > c0), 32'd1);
    chk("random_volume", 32'(n_consumed > 500), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Produces the 32-bit instruction word and its PC for the instruction decoder / control unit. This is the producer end of the `instr` interface.
- Issues word-aligned requests to instruction memory and buffers in-order responses in a small prefetch queue.
- Presents the head of the queue to decode through a valid/ready handshake.
- Accepts a redirect (taken branch/jump, driven from the decoder's PCsrc path) that flushes the queue and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset (bits [1:0] must be 0).
- DEPTH, 4, prefetch queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  byte address of the request, always word aligned.
- imem_rsp_valid  in  1  response valid. Responses are in order, one per accepted request, arrive >= 1 cycle after acceptance, and are never back-pressured.
- imem_rsp_data  in  32  instruction word.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decoder consumes the head this cycle.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.
- redirect  in  1  taken branch/jump; overrides sequential fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- halt  in  1  stop issuing new requests; responses already in flight still complete.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to BOOT; fetch_pc = RESET_PC.
  - Queue empty; outstanding = 0; discard = 0.
  - imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
- FSM states:
  - BOOT: one cycle after reset release, then RUN. No requests are issued in BOOT.
  - RUN: issues requests. RUN -> HALT when halt = 1.
  - HALT: imem_req_valid = 0. HALT -> RUN when halt = 0.
  - A redirect is honoured in every state; it does not change the state, except that a redirect in BOOT also moves to RUN.
- Credit rule:
  - imem_req_valid = (state == RUN) && (count + outstanding < DEPTH).
  - imem_req_valid depends only on registered state.
  - imem_addr = fetch_pc.
  - Guarantees every response has a free queue slot, so the queue never overflows.
- Request acceptance (imem_req_valid && imem_req_ready):
  - fetch_pc += 4 (wraps modulo 2^32).
  - outstanding += 1.
  - The pc is pushed into a pc-tag FIFO, DEPTH deep, which travels with the request.
- Response arrival:
  - If discard > 0: discard -= 1, the word is dropped, and the tag FIFO is popped.
  - Otherwise the word and its tag are pushed into the queue.
  - In both cases outstanding -= 1.
- Decode handshake:
  - instr_valid = !empty; instr and instr_pc show the head.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - While instr_valid = 1 and instr_ready = 0, instr and instr_pc hold stable.
- Redirect cycle (redirect = 1), applied at the next edge:
  - Queue cleared (instr_valid = 0 next cycle); a pop in the same cycle is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - discard = outstanding_next, i.e. every in-flight request, including one accepted in this same cycle and excluding a response consumed in this same cycle.
  - Tag FIFO is not cleared; discarded tags drain with their responses.
- Latency:
  - First request is issued 1 cycle after reset release.
  - instr_valid rises the cycle after imem_rsp_valid.
  - After a redirect, the first new request is issued the cycle after the redirect. This holds if credit is available.
- Counter widths: count, outstanding and discard are $clog2(DEPTH+1) bits. Assertions required:
  - outstanding <= DEPTH
  - discard <= outstanding
  - no response while outstanding == 0
- halt during a redirect: the redirect is still applied; fetch_pc updates, but no requests are issued until halt drops.

Decomposition:
- Shared package cpu_pkg:
  - XLEN = 32
  - INSTR_NOP = 32'h0000_0013
  - fetch_state_t enum {BOOT, RUN, HALT}
- One sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, wdata, rdata, empty, full, count).
  - Instantiated twice: prefetch queue (WIDTH = 64: instruction word + pc) and pc-tag FIFO (WIDTH = 32).

Test Plan:
1. Reset release, imem_req_ready = 1, 1-cycle response latency, instr_ready = 1 -> requests at 0x0, 0x4, 0x8…; instr_pc sequence 0x0, 0x4, 0x8, one per cycle in steady state.
2. instr_ready = 0 for 10 cycles -> exactly 4 requests issued, queue full, imem_req_valid = 0; instr stable at pc 0x0; resuming ready drains 0x0..0xC in order.
3. 3-cycle response latency, redirect to 0x100 with 2 requests outstanding -> both stale responses dropped; next instr_pc = 0x100; no stale word ever has instr_valid high.
4. Redirect in the same cycle as a request acceptance and a response arrival -> discard equals the correct count; the first instruction after the redirect is from redirect_pc; the assertions hold.
5. redirect_pc = 0x203 -> imem_addr = 0x200. fetch_pc = 0xFFFF_FFFC followed by one acceptance -> imem_addr wraps to 0x0.
6. halt asserted mid-stream with 2 outstanding -> no new requests; both responses are queued and delivered. Reset asserted mid-stream -> all outputs 0 asynchronously; refetch starts at RESET_PC.
